// File: rtl/bg_mosaic_sampler.sv
// Applies mosaic strobes to the per-BG pixel streams and produces the
// block-aligned fetch line for each BG tile fetcher.
module bg_mosaic_sampler #(
    parameter int NUM_BG = 4,
    parameter int PIX_W  = 12,
    parameter int Y_W    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dot_en,
    input  logic                    newline,
    input  logic                    period_start,
    input  logic                    pixel_strobe,
    input  logic [3:0]              yofs_subtract,
    input  logic [NUM_BG-1:0]       mosaic_en_reg,
    input  logic [Y_W-1:0]          vpos,
    input  logic [NUM_BG*PIX_W-1:0] pix_in,
    output logic [NUM_BG*PIX_W-1:0] pix_out,
    output logic [NUM_BG*Y_W-1:0]   fetch_y,
    output logic [NUM_BG-1:0]       en_line,
    output logic                    y_underflow
);

    logic [NUM_BG-1:0]       en_line_q, en_line_d;
    logic [NUM_BG*PIX_W-1:0] hold_q, hold_d;
    logic                    y_underflow_q, y_underflow_d;

    // One shared subtraction: every enabled BG uses the same row offset.
    logic [Y_W:0] yofs_ext;
    logic [Y_W:0] y_diff;
    logic         y_borrow;

    assign yofs_ext = {{(Y_W + 1 - 4){1'b0}}, yofs_subtract};
    assign y_diff   = {1'b0, vpos} - yofs_ext;
    assign y_borrow = y_diff[Y_W];

    always_comb begin
        en_line_d     = en_line_q;
        y_underflow_d = y_underflow_q;
        if (dot_en) begin
            if (newline) begin
                en_line_d = mosaic_en_reg;
            end
            if (y_borrow && (|en_line_q)) begin
                y_underflow_d = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_bg
            // Disabled BGs reload every dot, giving the same 1-dot latency.
            always_comb begin
                hold_d[gi*PIX_W +: PIX_W] = hold_q[gi*PIX_W +: PIX_W];
                if (dot_en && (pixel_strobe || period_start || !en_line_q[gi])) begin
                    hold_d[gi*PIX_W +: PIX_W] = pix_in[gi*PIX_W +: PIX_W];
                end
            end

            always_comb begin
                fetch_y[gi*Y_W +: Y_W] = vpos;
                if (en_line_q[gi]) begin
                    fetch_y[gi*Y_W +: Y_W] = y_borrow ? '0 : y_diff[Y_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            en_line_q     <= '0;
            hold_q        <= '0;
            y_underflow_q <= 1'b0;
        end else begin
            en_line_q     <= en_line_d;
            hold_q        <= hold_d;
            y_underflow_q <= y_underflow_d;
        end
    end

    assign pix_out     = hold_q;
    assign en_line     = en_line_q;
    assign y_underflow = y_underflow_q;

endmodule
